period_meter: RTL and testbench

Parametrised input period meter. It measures the clk-cycle distance between selected edges of an asynchronous input, keeps a moving average over a power-of-two window, and flags loss of signal against a programmable timeout. It is the generalised successor to the team's fixed 16-bit period counter and feeds the same downstream frequency-readout logic.

---
 rtl/period_meter.sv | 137 +++++++++++++
 tb/tb_period_meter.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/period_meter.sv
`default_nettype none
// ============================================================================
// Module      : period_meter
// Description : Measures the clk-cycle distance between selected edges of an
//               asynchronous input. Keeps a moving average over a 2^AVG_LOG2
//               window and flags loss of signal against a timeout.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module period_meter #(
  parameter int CNT_W       = 16,
  parameter int AVG_LOG2    = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic [1:0]       edge_sel,
  input  logic [CNT_W-1:0] timeout,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] avg,
  output logic             valid,
  output logic             nosignal
);

  localparam int c_depth  = 1 << AVG_LOG2;
  localparam int c_sum_w  = CNT_W + AVG_LOG2;
  localparam int c_fill_w = AVG_LOG2 + 1;
  localparam logic [c_fill_w-1:0] c_full    = c_fill_w'(c_depth);
  localparam logic [CNT_W-1:0]    c_cnt_max = '1;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_dly;
  logic                   w_s;
  logic                   w_edge;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_armed;
  logic                   w_accept;
  logic                   w_lost;
  logic [CNT_W-1:0]       r_win [c_depth];
  logic [c_sum_w-1:0]     r_sum;
  logic [c_sum_w-1:0]     w_sum_next;
  logic [c_fill_w-1:0]    r_fill;
  logic [c_fill_w-1:0]    w_fill_next;

  assign w_s = r_sync[SYNC_STAGES-1];

  // Synchroniser chain followed by the delay flop used for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= '0;
      r_dly  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], in};
      r_dly  <= w_s;
    end
  end

  // Edge event selection; code 11 behaves as rising
  always_comb begin
    w_edge = 1'b0;
    case (edge_sel)
      2'b01:   w_edge = ~w_s & r_dly;
      2'b10:   w_edge = w_s ^ r_dly;
      default: w_edge = w_s & ~r_dly;
    endcase
  end

  // A sample only counts once armed and signal present; an edge beats a timeout
  always_comb begin
    w_accept    = w_edge & r_armed & ~nosignal;
    w_lost      = (timeout != '0) & r_armed & (r_cnt == timeout) & ~w_edge;
    w_sum_next  = r_sum + c_sum_w'(r_cnt) - c_sum_w'(r_win[c_depth-1]);
    w_fill_next = (r_fill == c_full) ? c_full : r_fill + c_fill_w'(1);
  end

  // Period counter: restarts at 1 on an event, saturates at all-ones
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (w_edge) begin
      r_cnt <= CNT_W'(1);
    end else if (r_cnt != c_cnt_max) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Arming and loss-of-signal flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_armed  <= 1'b0;
      nosignal <= 1'b1;
    end else if (w_edge) begin
      r_armed  <= 1'b1;
      nosignal <= 1'b0;
    end else if (w_lost) begin
      nosignal <= 1'b1;
    end
  end

  // Averaging window, running sum and fill level; flushed on loss of signal
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < c_depth; i++) r_win[i] <= '0;
      r_sum  <= '0;
      r_fill <= '0;
    end else if (w_accept) begin
      r_win[0] <= r_cnt;
      for (int i = 1; i < c_depth; i++) r_win[i] <= r_win[i-1];
      r_sum  <= w_sum_next;
      r_fill <= w_fill_next;
    end else if (w_lost) begin
      for (int i = 0; i < c_depth; i++) r_win[i] <= '0;
      r_sum  <= '0;
      r_fill <= '0;
    end
  end

  // Published sample, average and the full-window valid pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      period <= '0;
      avg    <= '0;
      valid  <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (w_accept) begin
        period <= r_cnt;
        if (w_fill_next == c_full) begin
          avg   <= w_sum_next[AVG_LOG2 +: CNT_W];
          valid <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_period_meter.sv
`default_nettype none
// ============================================================================
// Module      : tb_period_meter
// Description : Self-checking bench for period_meter with a behavioural model
//               built on event timestamps and a sample queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_period_meter;

  localparam int S  = 2;
  localparam int NW = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in  = 1'b0;
  logic [1:0]  edge_sel = 2'b00;
  logic [15:0] timeout  = '0;
  logic [15:0] period, avg;
  logic        valid, nosignal;
  logic [7:0]  period8, avg8;
  logic        valid8, nosignal8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  period_meter #(.CNT_W(16), .AVG_LOG2(2), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst(rst), .in(in), .edge_sel(edge_sel), .timeout(timeout),
    .period(period), .avg(avg), .valid(valid), .nosignal(nosignal)
  );

  period_meter #(.CNT_W(8), .AVG_LOG2(2), .SYNC_STAGES(S)) dut8 (
    .clk(clk), .rst(rst), .in(in), .edge_sel(edge_sel), .timeout(8'd0),
    .period(period8), .avg(avg8), .valid(valid8), .nosignal(nosignal8)
  );

  // ---------------- behavioural reference model (16-bit instance) ----------
  logic hist [0:S];
  int   m_t = 0, m_te = 0, m_period = 0, m_avg = 0, m_dist, m_sum;
  logic m_armed = 1'b0, m_nosig = 1'b1, m_valid = 1'b0, m_s, m_d, m_ev;
  int   m_q[$];

  initial begin
    for (int j = 0; j <= S; j++) hist[j] = 1'b0;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        for (int j = 0; j <= S; j++) hist[j] = 1'b0;
        m_t = 0; m_te = 0; m_period = 0; m_avg = 0;
        m_armed = 1'b0; m_nosig = 1'b1; m_valid = 1'b0;
        m_q.delete();
      end else begin
        m_s = hist[S-1];
        m_d = hist[S];
        case (edge_sel)
          2'b01:   m_ev = !m_s && m_d;
          2'b10:   m_ev = m_s != m_d;
          default: m_ev = m_s && !m_d;
        endcase
        m_t++;
        m_dist = m_t - m_te;
        if (m_dist > 65535) m_dist = 65535;
        m_valid = 1'b0;
        if (m_ev) begin
          if (!m_armed || m_nosig) begin
            m_armed = 1'b1;
            m_nosig = 1'b0;
          end else begin
            m_period = m_dist;
            m_q.push_back(m_dist);
            if (m_q.size() > NW) void'(m_q.pop_front());
            if (m_q.size() == NW) begin
              m_sum = 0;
              foreach (m_q[k]) m_sum += m_q[k];
              m_avg   = m_sum / NW;
              m_valid = 1'b1;
            end
          end
          m_te = m_t;
        end else if (timeout != 0 && m_armed && m_dist == int'(timeout)) begin
          m_nosig = 1'b1;
          m_q.delete();
        end
        for (int j = S; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = in;
      end
    end
  end

  // ---------------- stimulus helpers (no checking) -------------------------
  task automatic apply_reset(input logic [1:0] es, input int to);
    @(negedge clk);
    rst = 1'b0; in = 1'b0; edge_sel = es; timeout = 16'(to);
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  // ---------------- tests --------------------------------------------------
  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({period, avg, valid, nosignal} !== {16'd0, 16'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset16 got p=%0d a=%0d v=%0b n=%0b want 0 0 0 1", period, avg, valid, nosignal);
    end
    checks++;
    if ({period8, avg8, valid8, nosignal8} !== {8'd0, 8'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset8 got p=%0d a=%0d v=%0b n=%0b want 0 0 0 1", period8, avg8, valid8, nosignal8);
    end
    apply_reset(2'b00, 0);
  endtask

  task automatic test_rising();
    int nv = 0;
    apply_reset(2'b00, 0);
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      checks++;
      if ({period, avg, valid, nosignal} !== {16'(m_period), 16'(m_avg), m_valid, m_nosig}) begin
        errors++;
        $display("FAIL rising c=%0d got p=%0d a=%0d v=%0b n=%0b want %0d %0d %0b %0b",
                 c, period, avg, valid, nosignal, m_period, m_avg, m_valid, m_nosig);
      end
      if (valid) begin
        nv++;
        checks++;
        if (avg !== 16'd10 || period !== 16'd10) begin
          errors++;
          $display("FAIL rising_avg got p=%0d a=%0d want 10 10", period, avg);
        end
      end
      in = (c % 10) < 5;
    end
    checks++;
    if (nv != 4) begin errors++; $display("FAIL rising_valid_count got %0d want 4", nv); end
  endtask

  task automatic test_both_edges();
    int nv = 0;
    apply_reset(2'b10, 0);
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      checks++;
      if ({period, avg, valid, nosignal} !== {16'(m_period), 16'(m_avg), m_valid, m_nosig}) begin
        errors++;
        $display("FAIL both c=%0d got p=%0d a=%0d v=%0b n=%0b want %0d %0d %0b %0b",
                 c, period, avg, valid, nosignal, m_period, m_avg, m_valid, m_nosig);
      end
      if (valid) begin
        nv++;
        checks++;
        if (avg !== 16'd5 || (period !== 16'd3 && period !== 16'd7)) begin
          errors++;
          $display("FAIL both_avg got p=%0d a=%0d want p 3|7 a 5", period, avg);
        end
      end
      in = (c % 10) < 3;
    end
    checks++;
    if (nv != 16) begin errors++; $display("FAIL both_valid_count got %0d want 16", nv); end
  endtask

  task automatic test_back_to_back();
    int nv = 0;
    apply_reset(2'b10, 0);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      checks++;
      if ({period, avg, valid, nosignal} !== {16'(m_period), 16'(m_avg), m_valid, m_nosig}) begin
        errors++;
        $display("FAIL b2b c=%0d got p=%0d a=%0d v=%0b n=%0b want %0d %0d %0b %0b",
                 c, period, avg, valid, nosignal, m_period, m_avg, m_valid, m_nosig);
      end
      if (valid) begin
        nv++;
        checks++;
        if (avg !== 16'd1 || period !== 16'd1) begin
          errors++;
          $display("FAIL b2b_avg got p=%0d a=%0d want 1 1", period, avg);
        end
      end
      if (c < 30) in = (c % 2) == 0;
    end
    checks++;
    if (nv != 26) begin errors++; $display("FAIL b2b_valid_count got %0d want 26", nv); end
  endtask

  task automatic test_window();
    int exp_avg[4] = '{9, 10, 11, 12};
    int n12 = 0;
    apply_reset(2'b00, 0);
    for (int c = 0; c < 130; c++) begin
      @(negedge clk);
      checks++;
      if ({period, avg, valid, nosignal} !== {16'(m_period), 16'(m_avg), m_valid, m_nosig}) begin
        errors++;
        $display("FAIL window c=%0d got p=%0d a=%0d v=%0b n=%0b want %0d %0d %0b %0b",
                 c, period, avg, valid, nosignal, m_period, m_avg, m_valid, m_nosig);
      end
      if (valid && period == 16'd12) begin
        if (n12 < 4) begin
          checks++;
          if (avg !== 16'(exp_avg[n12])) begin
            errors++;
            $display("FAIL window_avg step=%0d got %0d want %0d", n12, avg, exp_avg[n12]);
          end
        end
        n12++;
      end
      in = (c < 64) ? ((c % 8) < 4) : (((c - 64) % 12) < 6);
    end
    checks++;
    if (n12 != 5) begin errors++; $display("FAIL window_count got %0d want 5", n12); end
  endtask

  task automatic test_timeout();
    int last_v = -1, rise_n = -1, nv = 0;
    apply_reset(2'b00, 50);
    for (int c = 0; c < 140; c++) begin
      @(negedge clk);
      checks++;
      if ({period, avg, valid, nosignal} !== {16'(m_period), 16'(m_avg), m_valid, m_nosig}) begin
        errors++;
        $display("FAIL timeout c=%0d got p=%0d a=%0d v=%0b n=%0b want %0d %0d %0b %0b",
                 c, period, avg, valid, nosignal, m_period, m_avg, m_valid, m_nosig);
      end
      if (valid) last_v = c;
      if (c > 20 && nosignal && rise_n < 0) rise_n = c;
      in = (c < 60) ? ((c % 10) < 5) : 1'b0;
    end
    checks++;
    if (last_v < 0 || rise_n - last_v != 50) begin
      errors++;
      $display("FAIL timeout_delay got %0d want 50", rise_n - last_v);
    end
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      checks++;
      if ({period, avg, valid, nosignal} !== {16'(m_period), 16'(m_avg), m_valid, m_nosig}) begin
        errors++;
        $display("FAIL rearm c=%0d got p=%0d a=%0d v=%0b n=%0b want %0d %0d %0b %0b",
                 c, period, avg, valid, nosignal, m_period, m_avg, m_valid, m_nosig);
      end
      if (valid) nv++;
      in = (c % 10) < 5;
    end
    checks++;
    if (nv != 4 || nosignal !== 1'b0) begin
      errors++;
      $display("FAIL rearm_valid_count got %0d nosig=%0b want 4 0", nv, nosignal);
    end
  endtask

  task automatic test_saturation();
    int nv = 0;
    apply_reset(2'b00, 0);
    for (int c = 0; c < 1650; c++) begin
      @(negedge clk);
      checks++;
      if ({period, avg, valid, nosignal} !== {16'(m_period), 16'(m_avg), m_valid, m_nosig}) begin
        errors++;
        $display("FAIL sat16 c=%0d got p=%0d a=%0d v=%0b n=%0b want %0d %0d %0b %0b",
                 c, period, avg, valid, nosignal, m_period, m_avg, m_valid, m_nosig);
      end
      if (valid8) begin
        nv++;
        checks++;
        if (period8 !== 8'd255 || avg8 !== 8'd255) begin
          errors++;
          $display("FAIL sat8 got p=%0d a=%0d want 255 255", period8, avg8);
        end
      end
      in = (c % 300) < 150;
    end
    checks++;
    if (nv != 2 || period8 !== 8'd255) begin
      errors++;
      $display("FAIL sat8_count got %0d p=%0d want 2 255", nv, period8);
    end
  endtask

  task automatic test_reset_mid();
    int nv = 0;
    apply_reset(2'b00, 0);
    for (int c = 0; c < 38; c++) begin
      @(negedge clk);
      in = (c % 10) < 5;
    end
    checks++;
    if (period !== 16'd10 || nosignal !== 1'b0) begin
      errors++;
      $display("FAIL pre_reset got p=%0d n=%0b want 10 0", period, nosignal);
    end
    @(negedge clk);
    rst = 1'b0; in = 1'b0;
    #1;
    checks++;
    if ({period, avg, valid, nosignal} !== {16'd0, 16'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_mid got p=%0d a=%0d v=%0b n=%0b want 0 0 0 1", period, avg, valid, nosignal);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      checks++;
      if ({period, avg, valid, nosignal} !== {16'(m_period), 16'(m_avg), m_valid, m_nosig}) begin
        errors++;
        $display("FAIL post_reset c=%0d got p=%0d a=%0d v=%0b n=%0b want %0d %0d %0b %0b",
                 c, period, avg, valid, nosignal, m_period, m_avg, m_valid, m_nosig);
      end
      if (c == 5) begin
        checks++;
        if (period !== 16'd0 || nosignal !== 1'b0) begin
          errors++;
          $display("FAIL arm_only got p=%0d n=%0b want 0 0", period, nosignal);
        end
      end
      if (valid) nv++;
      in = (c % 10) < 5;
    end
    checks++;
    if (nv != 2) begin errors++; $display("FAIL post_reset_count got %0d want 2", nv); end
  endtask

  task automatic test_random();
    int rem;
    for (int r = 0; r < 6; r++) begin
      apply_reset(2'($urandom_range(0, 3)), ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(15, 60)));
      rem = 1;
      for (int c = 0; c < 400; c++) begin
        @(negedge clk);
        checks++;
        if ({period, avg, valid, nosignal} !== {16'(m_period), 16'(m_avg), m_valid, m_nosig}) begin
          errors++;
          $display("FAIL random r=%0d c=%0d got p=%0d a=%0d v=%0b n=%0b want %0d %0d %0b %0b",
                   r, c, period, avg, valid, nosignal, m_period, m_avg, m_valid, m_nosig);
        end
        rem--;
        if (rem == 0) begin
          in  = ~in;
          rem = ($urandom_range(0, 9) == 0) ? int'($urandom_range(40, 90)) : int'($urandom_range(1, 20));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_rising();
    test_both_edges();
    test_back_to_back();
    test_window();
    test_timeout();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
